// File: rtl/puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer
//
// Drives an arbiter-PUF chain. For each challenge (taken from an 8-bit LFSR)
// it launches C_VOTES races. Each race is a low settle phase followed by a
// high pulse phase, and then one sample cycle. The races are majority-voted
// into one response bit. C_RESP_BITS bits are collected into a response
// word, which is then offered to a consumer.
//
// Handshake: oready is high only while IDLE; istart is accepted on any edge
// where oready=1. ovalid is high only while DONE and stays high until a
// rising edge sees iack=1; the sequencer returns to IDLE on that edge.
// istart outside IDLE and iack outside DONE have no effect.
//
// Ports
//   iclk            clock, rising edge
//   irst            synchronous active-high reset
//   istart          start request (IDLE only)
//   iseed [7:0]     LFSR seed captured with istart (0 is replaced by 8'h01)
//   ochallenge[7:0] challenge to the arbiter chain (LFSR register)
//   opulse          race launch pulse
//   iresponse       arbiter output, asynchronous to iclk
//   oready          idle / ready for istart
//   ovalid          response word available
//   iack            consumer acknowledge
//   oresponse_word  majority-voted response bits, first challenge in the MSB
//   ounstable [3:0] count of non-unanimous bits, saturating at 15
//   ostate [2:0]    current FSM state (debug)
// ---------------------------------------------------------------------------
module puf_challenge_sequencer #(
   parameter int C_SETTLE    = 4,
   parameter int C_VOTES     = 7,
   parameter int C_RESP_BITS = 8
) (
   input  logic                   iclk,
   input  logic                   irst,
   input  logic                   istart,
   input  logic [7:0]             iseed,
   output logic [7:0]             ochallenge,
   output logic                   opulse,
   input  logic                   iresponse,
   output logic                   oready,
   output logic                   ovalid,
   input  logic                   iack,
   output logic [C_RESP_BITS-1:0] oresponse_word,
   output logic [3:0]             ounstable,
   output logic [2:0]             ostate
);

   // Wide enough to hold C_RESP_BITS itself so the counter never wraps.
   localparam int BW = $clog2(C_RESP_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_FIRE   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DECIDE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [3:0]             phase_cnt;
   logic [3:0]             vote_cnt;
   logic [3:0]             ones;
   logic [BW-1:0]          bit_cnt;
   logic [7:0]             lfsr;
   logic [C_RESP_BITS-1:0] word;
   logic [3:0]             unstable;
   logic                   resp_meta;
   logic                   resp_sync;

   logic                   phase_last;
   logic                   vote_last;
   logic                   bit_last;
   logic                   decided_bit;
   logic                   unanimous;

   assign phase_last  = (phase_cnt == 4'(C_SETTLE - 1));
   assign vote_last   = (vote_cnt == 4'(C_VOTES - 1));
   assign bit_last    = (bit_cnt == BW'(C_RESP_BITS - 1));
   assign decided_bit = (ones > 4'(C_VOTES / 2));
   assign unanimous   = (ones == 4'd0) || (ones == 4'(C_VOTES));

   // ---------------- state register ----------------
   always_ff @(posedge iclk) begin
      if (irst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (istart)     state_nxt = S_SETUP;
         S_SETUP:  if (phase_last) state_nxt = S_FIRE;
         S_FIRE:   if (phase_last) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = vote_last ? S_DECIDE : S_SETUP;
         S_DECIDE: state_nxt = bit_last ? S_DONE : S_SETUP;
         S_DONE:   if (iack)       state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   // Pure decode of the state register, so no input reaches an output
   // combinationally.
   always_comb begin
      oready = 1'b0;
      ovalid = 1'b0;
      opulse = 1'b0;
      case (state)
         S_IDLE:           oready = 1'b1;
         S_FIRE, S_SAMPLE: opulse = 1'b1;
         S_DONE:           ovalid = 1'b1;
         default:          ;
      endcase
   end

   assign ostate         = state;
   assign ochallenge     = lfsr;
   assign oresponse_word = word;
   assign ounstable      = unstable;

   // ---------------- datapath ----------------
   always_ff @(posedge iclk) begin
      if (irst) begin
         resp_meta <= 1'b0;
         resp_sync <= 1'b0;
         phase_cnt <= '0;
         vote_cnt  <= '0;
         ones      <= '0;
         bit_cnt   <= '0;
         lfsr      <= 8'h00;
         word      <= '0;
         unstable  <= '0;
      end else begin
         // Two-flop synchronizer; only resp_sync is ever used.
         resp_meta <= iresponse;
         resp_sync <= resp_meta;

         case (state)
            S_IDLE: begin
               if (istart) begin
                  // An all-zero LFSR would lock up, so a zero seed is replaced.
                  lfsr      <= (iseed == 8'h00) ? 8'h01 : iseed;
                  phase_cnt <= '0;
                  vote_cnt  <= '0;
                  ones      <= '0;
                  bit_cnt   <= '0;
                  word      <= '0;
                  unstable  <= '0;
               end
            end
            S_SETUP, S_FIRE: begin
               // Shared phase counter; it restarts at each phase boundary.
               phase_cnt <= phase_last ? 4'd0 : phase_cnt + 4'd1;
            end
            S_SAMPLE: begin
               ones     <= ones + {3'b000, resp_sync};
               vote_cnt <= vote_cnt + 4'd1;
            end
            S_DECIDE: begin
               word     <= {word[C_RESP_BITS-2:0], decided_bit};
               lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               ones     <= '0;
               vote_cnt <= '0;
               bit_cnt  <= bit_cnt + 1'b1;
               if (!unanimous && (unstable != 4'hF)) unstable <= unstable + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_puf_challenge_sequencer
//
// Scenario tasks drive the sequencer with fixed per-vote response patterns.
// The expected {word, unstable} pair of each run is pushed to exp_q when the
// run starts and popped when ovalid rises. The expected challenge sequence,
// pulse shape and ovalid timing are derived from the cycle count since the
// start edge.
// ---------------------------------------------------------------------------
module tb_puf_challenge_sequencer;

   localparam int S   = 4;
   localparam int V   = 7;
   localparam int N   = 8;
   localparam int VL  = 2 * S + 1;   // cycles per vote
   localparam int BL  = V * VL + 1;  // cycles per response bit
   localparam int LAT = N * BL;      // start edge to ovalid

   logic         iclk;
   logic         irst;
   logic         istart;
   logic [7:0]   iseed;
   logic [7:0]   ochallenge;
   logic         opulse;
   logic         iresponse;
   logic         oready;
   logic         ovalid;
   logic         iack;
   logic [N-1:0] oresponse_word;
   logic [3:0]   ounstable;
   logic [2:0]   ostate;

   int errors = 0;
   int checks = 0;
   logic [N+3:0] exp_q[$];

   puf_challenge_sequencer #(
      .C_SETTLE(S), .C_VOTES(V), .C_RESP_BITS(N)
   ) dut (
      .iclk(iclk), .irst(irst), .istart(istart), .iseed(iseed),
      .ochallenge(ochallenge), .opulse(opulse), .iresponse(iresponse),
      .oready(oready), .ovalid(ovalid), .iack(iack),
      .oresponse_word(oresponse_word), .ounstable(ounstable), .ostate(ostate)
   );

   // ---------------- clock ----------------
   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      irst = 1'b1; istart = 1'b1; iseed = 8'h77; iack = 1'b1; iresponse = 1'b1;
      tick(); tick();
      istart = 1'b0; iack = 1'b0;
      checks++; if (opulse !== 1'b0)     begin errors++; $display("FAIL reset_opulse got=%b exp=0", opulse); end
      checks++; if (oready !== 1'b1)     begin errors++; $display("FAIL reset_oready got=%b exp=1", oready); end
      checks++; if (ovalid !== 1'b0)     begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
      checks++; if (ochallenge !== 8'h00) begin errors++; $display("FAIL reset_challenge got=%h exp=00", ochallenge); end
      checks++; if (oresponse_word !== '0) begin errors++; $display("FAIL reset_word got=%h exp=00", oresponse_word); end
      checks++; if (ounstable !== 4'd0)  begin errors++; $display("FAIL reset_unstable got=%0d exp=0", ounstable); end
      irst = 1'b0;
      tick();
      // istart was held with irst, so it must not have launched a run.
      checks++; if (oready !== 1'b1) begin errors++; $display("FAIL reset_priority oready got=%b exp=1", oready); end
   endtask

   // Runs one full word. votes[k] is the response level for vote k, repeated
   // on every challenge.
   task automatic run_word(input string name, input logic [7:0] seed,
                           input logic [14:0] votes, input logic [7:0] ch0,
                           input logic [7:0] ch1, input int hold, input bit poke);
      logic [7:0]   lf;
      int           ones_e;
      logic         b;
      logic [N+3:0] exp;
      int           waited;
      int           bo;
      bit           exp_pulse;

      ones_e = 0;
      for (int i = 0; i < V; i++) ones_e += int'(votes[i]);
      b = (ones_e > V / 2);
      exp_q.push_back({(b ? {N{1'b1}} : {N{1'b0}}),
                       ((ones_e != 0 && ones_e != V) ? 4'(N) : 4'd0)});

      waited = 0;
      while (oready !== 1'b1 && waited < 20) begin tick(); waited++; end
      checks++; if (oready !== 1'b1) begin errors++; $display("FAIL %s ready_wait got=%b exp=1", name, oready); end

      iseed = seed; istart = 1'b1;
      tick();
      istart = 1'b0;
      lf = (seed == 8'h00) ? 8'h01 : seed;

      for (int t = 0; t < LAT; t++) begin
         bo = t % BL;
         if (bo < V * VL) begin
            if (bo % VL == 0) iresponse = votes[bo / VL];
            exp_pulse = ((bo % VL) >= S);
         end else begin
            exp_pulse = 1'b0;
         end
         if (t == 0) begin
            checks++; if (ochallenge !== ch0) begin errors++; $display("FAIL %s first_challenge got=%h exp=%h", name, ochallenge, ch0); end
         end
         if (t == BL) begin
            checks++; if (ochallenge !== ch1) begin errors++; $display("FAIL %s second_challenge got=%h exp=%h", name, ochallenge, ch1); end
         end
         checks++; if (ochallenge !== lf) begin errors++; $display("FAIL %s challenge t=%0d got=%h exp=%h", name, t, ochallenge, lf); end
         checks++; if (opulse !== exp_pulse) begin errors++; $display("FAIL %s pulse t=%0d got=%b exp=%b", name, t, opulse, exp_pulse); end
         checks++; if (ovalid !== 1'b0 || oready !== 1'b0) begin errors++; $display("FAIL %s busy t=%0d ovalid=%b oready=%b exp=0/0", name, t, ovalid, oready); end
         if (poke && t == 100) begin istart = 1'b1; iack = 1'b1; end
         if (poke && t == 101) begin istart = 1'b0; iack = 1'b0; end
         if (bo == BL - 1) lf = lfsr_step(lf);
         tick();
      end

      checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL %s latency ovalid got=%b exp=1", name, ovalid); end
      if (exp_q.size() == 0) begin
         errors++; checks++; $display("FAIL %s scoreboard empty", name);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (oresponse_word !== exp[N+3:4]) begin errors++; $display("FAIL %s word got=%h exp=%h", name, oresponse_word, exp[N+3:4]); end
         checks++; if (ounstable !== exp[3:0]) begin errors++; $display("FAIL %s unstable got=%0d exp=%0d", name, ounstable, exp[3:0]); end

         for (int h = 0; h < hold; h++) begin
            istart = (poke && h == 5);
            tick();
            checks++; if (ovalid !== 1'b1 || oready !== 1'b0) begin errors++; $display("FAIL %s hold h=%0d ovalid=%b oready=%b exp=1/0", name, h, ovalid, oready); end
            checks++; if (oresponse_word !== exp[N+3:4]) begin errors++; $display("FAIL %s hold_word h=%0d got=%h exp=%h", name, h, oresponse_word, exp[N+3:4]); end
         end
      end
      istart = 1'b0;

      iack = 1'b1;
      tick();
      iack = 1'b0;
      checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL %s ack_ovalid got=%b exp=0", name, ovalid); end
      checks++; if (oready !== 1'b1) begin errors++; $display("FAIL %s ack_oready got=%b exp=1", name, oready); end
   endtask

   task automatic test_reset_mid_fire();
      int  bo;
      bit  saw_valid;
      iseed = 8'h5A; istart = 1'b1;
      tick();
      istart = 1'b0;
      // Alternating votes make bits 0 and 1 non-unanimous before the abort.
      for (int t = 0; t < 2 * BL + S + 1; t++) begin
         bo = t % BL;
         if (bo < V * VL && bo % VL == 0) iresponse = ((bo / VL) % 2 == 0);
         tick();
      end
      checks++; if (opulse !== 1'b1) begin errors++; $display("FAIL midrst in_fire opulse got=%b exp=1", opulse); end
      checks++; if (ounstable !== 4'd2) begin errors++; $display("FAIL midrst pre_unstable got=%0d exp=2", ounstable); end
      irst = 1'b1;
      tick();
      checks++; if (opulse !== 1'b0) begin errors++; $display("FAIL midrst opulse got=%b exp=0", opulse); end
      checks++; if (oready !== 1'b1) begin errors++; $display("FAIL midrst oready got=%b exp=1", oready); end
      checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL midrst ovalid got=%b exp=0", ovalid); end
      checks++; if (ounstable !== 4'd0) begin errors++; $display("FAIL midrst unstable got=%0d exp=0", ounstable); end
      checks++; if (ochallenge !== 8'h00) begin errors++; $display("FAIL midrst challenge got=%h exp=00", ochallenge); end
      tick();
      irst = 1'b0;
      saw_valid = 1'b0;
      for (int t = 0; t < LAT + 50; t++) begin
         tick();
         if (ovalid !== 1'b0 || oready !== 1'b1) saw_valid = 1'b1;
      end
      checks++; if (saw_valid) begin errors++; $display("FAIL midrst no_restart got=1 exp=0"); end
   endtask

   // ---------------- sequence ----------------
   initial begin
      irst = 1'b1; istart = 1'b0; iseed = 8'h00; iack = 1'b0; iresponse = 1'b0;
      test_reset();
      run_word("seed_a5_ones",  8'hA5, 15'h7FFF, 8'hA5, 8'h4A, 3, 1'b0);
      run_word("seed_00_zeros", 8'h00, 15'h0000, 8'h01, 8'h02, 2, 1'b0);
      run_word("toggle_votes",  8'h3C, 15'b000_0000_0101_0101, 8'h3C, 8'h79, 2, 1'b0);
      run_word("four_three",    8'hC3, 15'b000_0000_0111_0000, 8'hC3, 8'h87, 20, 1'b1);
      run_word("back_to_back",  8'hA5, 15'h7FFF, 8'hA5, 8'h4A, 0, 1'b0);
      test_reset_mid_fire();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SHALL have parameter C_SETTLE, default 4: clock cycles per pulse-low and pulse-high phase; legal range 3..15.
REQ-002 SHALL have parameter C_VOTES, default 7: race repetitions per challenge; odd only, legal range 1..15.
REQ-003 SHALL have parameter C_RESP_BITS, default 8: challenges, and therefore response bits, per response word.
REQ-004 SHALL have port iclk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-005 SHALL have port irst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port istart, input, 1 bit: start request; sampled only in IDLE.
REQ-007 SHALL have port iseed, input, 8 bits: LFSR seed, captured when istart is accepted.
REQ-008 SHALL have port ochallenge, output, 8 bits: challenge applied to the arbiter chain.
REQ-009 SHALL have port opulse, output, 1 bit: race launch pulse to the arbiter chain.
REQ-010 SHALL have port iresponse, input, 1 bit: arbiter response bit; asynchronous to iclk.
REQ-011 SHALL have port oready, output, 1 bit: high only in IDLE.
REQ-012 SHALL have port ovalid, output, 1 bit: response word available; high only in DONE.
REQ-013 SHALL have port iack, input, 1 bit: consumer acknowledge of the response word.
REQ-014 SHALL have port oresponse_word, output, C_RESP_BITS bits: majority-voted response bits.
REQ-015 SHALL have port ounstable, output, 4 bits: count of non-unanimous bits in the current word; saturates at 15.

Function
REQ-016 SHALL pass iresponse through a 2-flop synchronizer; only the synchronized value is used.
REQ-017 SHALL drive every output from a register or from a decode of the state register, with no combinational path from any input.
REQ-018 SHALL implement states IDLE, SETUP, FIRE, SAMPLE, DECIDE and DONE.
REQ-019 IDLE: istart=1 SHALL load lfsr=iseed (8'h01 if iseed=8'h00), clear counters, ones, word and ounstable, and go to SETUP; otherwise SHALL remain in IDLE.
REQ-020 SETUP: opulse=0 for exactly C_SETTLE cycles, then go to FIRE.
REQ-021 FIRE: opulse=1 for exactly C_SETTLE cycles, then go to SAMPLE.
REQ-022 SAMPLE: one cycle with opulse=1; SHALL add the synchronized response to ones and increment vote_cnt.
REQ-023 SAMPLE exit: if vote_cnt equals C_VOTES-1 before the increment, go to DECIDE; otherwise go to SETUP.
REQ-024 DECIDE: one cycle with opulse=0; bit = (ones > C_VOTES/2); word <= {word[C_RESP_BITS-2:0], bit}.
REQ-025 DECIDE SHALL increment ounstable (saturating at 15) when ones is neither 0 nor C_VOTES.
REQ-026 DECIDE SHALL step the lfsr, clear ones and vote_cnt, and increment bit_cnt.
REQ-027 DECIDE exit: if bit_cnt equals C_RESP_BITS-1 before the increment, go to DONE; otherwise go to SETUP.
REQ-028 LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; ochallenge = lfsr at all times.
REQ-029 ochallenge SHALL be stable for the whole of every SETUP/FIRE/SAMPLE window.
REQ-030 DONE: ovalid=1; oresponse_word and ounstable held; iack=1 SHALL go to IDLE, with ovalid low on the next cycle.
REQ-031 ovalid SHALL remain high indefinitely until iack=1.
REQ-032 istart SHALL be ignored in every state except IDLE; iack SHALL be ignored in every state except DONE.
REQ-033 Latency: ovalid SHALL rise exactly C_RESP_BITS*(C_VOTES*(2*C_SETTLE+1)+1) cycles after the edge that accepts istart (512 cycles at defaults).
REQ-034 Counters (ones, vote_cnt, bit_cnt) SHALL be sized for their parameter maxima, with no wrap within a run.

Reset
REQ-035 irst=1 on an edge SHALL force IDLE and set ochallenge=8'h00, opulse=0, oready=1, ovalid=0, oresponse_word=0, ounstable=0, clear all counters and clear both synchronizer flops.
REQ-036 irst SHALL take priority over istart and iack on the same edge.
REQ-037 irst asserted mid-run SHALL abort the run, drive opulse low on the next cycle and produce no ovalid.

Verification
REQ-038 Reset during FIRE (2 cycles) -> next cycle: opulse=0, oready=1, ovalid=0, ounstable=0.
REQ-039 iseed=8'hA5, iresponse held at 1 -> first ochallenge=8'hA5, second=8'h4A; ovalid at cycle 512; word=8'hFF; ounstable=0.
REQ-040 iseed=8'h00 -> first ochallenge=8'h01; iresponse held at 0 -> word=8'h00, ounstable=0.
REQ-041 iresponse toggled per vote 1,0,1,0,1,0,1 on every challenge -> word=8'hFF, ounstable=8.
REQ-042 iresponse=0 for 4 votes then 1 for 3 votes on every challenge -> word=8'h00, ounstable=8.
REQ-043 iack held low 20 cycles in DONE, with istart pulsed during the run -> ovalid stays high, word unchanged, no restart; iack=1 -> oready=1 on the next cycle.
